// File: rtl/stopwatch_lap_ctrl.sv
// Lap memory and viewer for a stopwatch: records live time on save, browses laps oldest-first.
// Define STOPWATCH_LAP_OVERWRITE_EN to make a save into a full buffer replace the oldest lap.
module stopwatch_lap_ctrl #(
  parameter int DEPTH       = 4,
  parameter int VIEW_CYCLES = 300_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_event_start,
  input  logic                       i_event_stop,
  input  logic                       i_event_clear,
  input  logic                       i_event_save,
  input  logic                       i_recall,
  input  logic [6:0]                 i_msec,
  input  logic [5:0]                 i_sec,
  input  logic [5:0]                 i_min,
  input  logic [4:0]                 i_hour,
  output logic [6:0]                 o_lap_msec,
  output logic [5:0]                 o_lap_sec,
  output logic [5:0]                 o_lap_min,
  output logic [4:0]                 o_lap_hour,
  output logic [$clog2(DEPTH)-1:0]   o_lap_idx,
  output logic [$clog2(DEPTH):0]     o_lap_count,
  output logic                       o_show_lap,
  output logic                       o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(VIEW_CYCLES + 1);
`ifdef STOPWATCH_LAP_OVERWRITE_EN
  localparam bit OVERWRITE = 1'b1;
`else
  localparam bit OVERWRITE = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, STOP, VIEW} state_t;

  state_t          state_reg;
  logic [23:0]     lap_mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_idx_reg;
  logic [CW-1:0]   count_reg;
  logic [TW-1:0]   timer_reg;
  logic [23:0]     lap_reg;
  logic            show_reg;

  logic            full;
  logic            run_evt;
  logic            save_write;
  logic            recall_ok;
  logic            enter_view;
  logic            advance;
  logic [AW-1:0]   oldest;
  logic [AW-1:0]   next_idx;
  logic [AW-1:0]   rd_addr;

  assign full    = (count_reg == CW'(DEPTH));
  // start/stop outrank save, which outranks recall; clear is handled first in the FSM
  assign run_evt = i_event_start | i_event_stop;
  assign save_write = !rst && !i_event_clear && !run_evt && i_event_save &&
                      (state_reg == RUN) && (!full || OVERWRITE);
  assign recall_ok  = !i_event_clear && !run_evt && !i_event_save && i_recall;
  assign enter_view = recall_ok && (state_reg == STOP) && (count_reg != '0);
  assign advance    = recall_ok && (state_reg == VIEW);

  // Oldest entry sits count slots behind the write pointer, which also covers overwrite mode.
  assign oldest   = wr_ptr_reg - AW'(count_reg);
  assign next_idx = (rd_idx_reg == AW'(count_reg - CW'(1))) ? '0 : rd_idx_reg + AW'(1);
  assign rd_addr  = oldest + (enter_view ? '0 : next_idx);

  always_ff @(posedge clk) begin
    if (save_write) lap_mem[wr_ptr_reg] <= {i_hour, i_min, i_sec, i_msec};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      wr_ptr_reg <= '0;
      rd_idx_reg <= '0;
      count_reg  <= '0;
      timer_reg  <= '0;
      lap_reg    <= '0;
      show_reg   <= 1'b0;
    end else if (i_event_clear) begin
      state_reg  <= IDLE;
      wr_ptr_reg <= '0;
      rd_idx_reg <= '0;
      count_reg  <= '0;
      timer_reg  <= '0;
      lap_reg    <= '0;
      show_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (i_event_start) state_reg <= RUN;
        RUN:  if (i_event_stop) state_reg <= STOP;
        STOP: begin
          if (i_event_start) begin
            state_reg <= RUN;
          end else if (enter_view) begin
            state_reg  <= VIEW;
            rd_idx_reg <= '0;
            timer_reg  <= TW'(VIEW_CYCLES - 1);
            lap_reg    <= lap_mem[rd_addr];
            show_reg   <= 1'b1;
          end
        end
        VIEW: begin
          if (i_event_start || (!advance && timer_reg == '0)) begin
            state_reg  <= i_event_start ? RUN : STOP;
            rd_idx_reg <= '0;
            timer_reg  <= '0;
            lap_reg    <= '0;
            show_reg   <= 1'b0;
          end else if (advance) begin
            rd_idx_reg <= next_idx;
            timer_reg  <= TW'(VIEW_CYCLES - 1);
            lap_reg    <= lap_mem[rd_addr];
          end else begin
            timer_reg <= timer_reg - TW'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
      if (save_write) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (!full) count_reg <= count_reg + CW'(1);
      end
    end
  end

  assign o_lap_hour  = lap_reg[23:19];
  assign o_lap_min   = lap_reg[18:13];
  assign o_lap_sec   = lap_reg[12:7];
  assign o_lap_msec  = lap_reg[6:0];
  assign o_lap_idx   = rd_idx_reg;
  assign o_lap_count = count_reg;
  assign o_show_lap  = show_reg;
  assign o_full      = full;
endmodule

// File: doc/stopwatch_lap_ctrl.md
STOPWATCH_LAP_CTRL -- requirements
Module: stopwatch_lap_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of lap entries (power of two, 2..8).
REQ-002 SHALL have parameter VIEW_CYCLES, default 300_000_000, idle cycles before lap view auto-exits (3 s at 100 MHz).
REQ-003 SHALL have one clock and a synchronous, active-high reset:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports:
- i_event_start  in  1  one-cycle pulse, stopwatch started.
- i_event_stop  in  1  one-cycle pulse, stopwatch stopped.
- i_event_clear  in  1  one-cycle pulse, stopwatch cleared.
- i_event_save  in  1  one-cycle pulse, lap request.
- i_recall  in  1  one-cycle pulse, show/advance stored lap.
- i_msec  in  7  live time, 0..99.
- i_sec  in  6  live time, 0..59.
- i_min  in  6  live time, 0..59.
- i_hour  in  5  live time, 0..23.
- o_lap_msec  out  7  displayed lap field.
- o_lap_sec  out  6  displayed lap field.
- o_lap_min  out  6  displayed lap field.
- o_lap_hour  out  5  displayed lap field.
- o_lap_idx  out  $clog2(DEPTH)  index of displayed lap, 0 = oldest.
- o_lap_count  out  $clog2(DEPTH)+1  number of valid laps.
- o_show_lap  out  1  high while in VIEW.
- o_full  out  1  o_lap_count == DEPTH.

Function
REQ-005 SHALL implement FSM states IDLE, RUN, STOP, VIEW.
REQ-006 SHALL use these transitions:
- IDLE -> RUN on start.
- RUN -> STOP on stop.
- STOP -> RUN on start.
- STOP -> VIEW on recall when count > 0.
- VIEW -> RUN on start.
- VIEW -> STOP on timeout.
- any state -> IDLE on clear.
REQ-007 SHALL apply priority clear > start/stop > save > recall when pulses coincide; a lower-priority pulse in the same cycle is ignored.
REQ-008 SHALL, on save in RUN, write {i_hour,i_min,i_sec,i_msec} as sampled in the save cycle into the circular buffer at the write pointer; o_lap_count updates the next cycle (1-cycle latency).
REQ-009 SHALL ignore save in IDLE, STOP and VIEW.
REQ-010 SHALL, on clear, reset count, write pointer and read index to 0; buffer contents need not be zeroed.
REQ-011 SHALL, on entry to VIEW, set o_lap_idx to 0 and drive the oldest lap on o_lap_* the next cycle.
REQ-012 SHALL, on each recall in VIEW, advance o_lap_idx by 1, wrapping from count-1 to 0; output updates the next cycle.
REQ-013 SHALL keep a view timer reloaded on VIEW entry and on each recall; after VIEW_CYCLES cycles with no recall, go to STOP.
REQ-014 SHALL ignore recall in STOP when count == 0 (stays in STOP).
REQ-015 SHALL drive o_lap_* to 0 and o_show_lap to 0 outside VIEW.
REQ-016 SHALL ignore recall in RUN and IDLE.

Reset
REQ-017 SHALL, while rst is high at a clk edge:
- state = IDLE.
- count, write pointer, read index and view timer = 0.
- all outputs = 0.
REQ-018 SHALL give rst priority over every event input, including mid-VIEW and mid-save.

Configuration
REQ-019 SHALL support macro STOPWATCH_LAP_OVERWRITE_EN:
- Defined: save when full overwrites the oldest entry; the oldest-entry pointer advances; count stays DEPTH; index 0 remains the oldest surviving lap.
- Undefined: save when full is dropped; buffer and count are unchanged; o_full stays 1.

Verification
REQ-020 Reset: rst high 1 cycle, then low -> all outputs 0, o_lap_count = 0, state IDLE.
REQ-021 Record and browse (VIEW_CYCLES = 16):
- start; save at 0:00:01.25 and 0:00:03.50; stop.
- recall -> o_show_lap = 1, idx 0 = 1 s 25.
- recall -> idx 1 = 3 s 50.
- recall -> idx 0 (wrap).
REQ-022 Full without macro:
- 5 saves with DEPTH = 4 -> count 4, o_full = 1.
- idx 0 holds the first lap; the 5th lap is discarded.
REQ-023 Full with STOPWATCH_LAP_OVERWRITE_EN:
- same stimulus as REQ-022 -> count 4.
- idx 0 = 2nd lap, idx 3 = 5th lap.
REQ-024 Simultaneous events:
- clear and save in the same RUN cycle -> count 0, IDLE.
- stop and save in the same cycle -> STOP, no lap written.
REQ-025 Timeout: in VIEW with VIEW_CYCLES = 16 and no recall -> o_show_lap falls after 16 cycles, state STOP; a later start -> RUN.
